// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
  localparam logic [63:0] IF_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IF_S_REQ  = 2'd0,
    IF_S_WAIT = 2'd1,
    IF_S_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry PC/instruction holding register between fetch and decode.
module if_fetch_stage_hold_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic                present_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [INST_LEN-1:0] instr_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [INST_LEN-1:0] instr_o
);

  logic [XLEN-1:0]     pc_q;
  logic [INST_LEN-1:0] instr_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      pc_q    <= '0;
      instr_q <= INST_LEN'(IF_NOP_INST);
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  // While not presented (reset cycle) the outputs show the idle values.
  assign pc_o    = present_i ? pc_q : '0;
  assign instr_o = present_i ? instr_q : INST_LEN'(IF_NOP_INST);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues requests, buffers one instruction for ID.
// Optional IF_MISALIGN_CHECK_EN: misaligned PCs raise if_excp_o instead of being fetched.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_jump_i,
  input  logic [XLEN-1:0]     pc_next_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  input  logic                mem_resp_valid_i,
  input  logic [INST_LEN-1:0] mem_resp_data_i,
  output logic                if_valid_o,
  input  logic                id_ready_i,
  output logic [XLEN-1:0]     pc_if_o,
  output logic [INST_LEN-1:0] instr_if_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                if_excp_o
`endif
);

  if_state_e           state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                hold_ld;
  logic [INST_LEN-1:0] hold_instr_d;
  logic                misalign;
  logic                req_fire;

`ifdef IF_MISALIGN_CHECK_EN
  logic excp_q, excp_d;
  assign misalign  = (pc_q[1:0] != 2'b00);
  assign if_excp_o = excp_q & ~rst;
`else
  assign misalign = 1'b0;
`endif

  assign mem_req_valid_o = (state_q == IF_S_REQ) & ~rst & ~misalign;
  assign mem_req_addr_o  = pc_q;
  assign if_valid_o      = (state_q == IF_S_HOLD) & ~rst;
  assign req_fire        = mem_req_valid_o & mem_req_ready_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_ld      = 1'b0;
    hold_instr_d = mem_resp_data_i;
`ifdef IF_MISALIGN_CHECK_EN
    excp_d       = excp_q;
`endif
    unique case (state_q)
      IF_S_REQ: begin
        if (misalign && !is_jump_i) begin
          state_d      = IF_S_HOLD;
          hold_ld      = 1'b1;
          hold_instr_d = INST_LEN'(IF_NOP_INST);
`ifdef IF_MISALIGN_CHECK_EN
          excp_d       = 1'b1;
`endif
        end else begin
          if (is_jump_i) pc_d = pc_next_i;
          // A redirect in the accept cycle makes the in-flight response wrong-path.
          if (req_fire) begin
            state_d = IF_S_WAIT;
            drop_d  = is_jump_i;
          end
        end
      end
      IF_S_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d = IF_S_REQ;
          drop_d  = 1'b0;
          if (is_jump_i) begin
            pc_d = pc_next_i;
          end else if (!drop_q) begin
            state_d = IF_S_HOLD;
            hold_ld = 1'b1;
            pc_d    = pc_q + XLEN'(4);
          end
        end else if (is_jump_i) begin
          pc_d   = pc_next_i;
          drop_d = 1'b1;
        end
      end
      IF_S_HOLD: begin
        // Redirect wins over a same-cycle ID handshake: the buffered instruction is wrong-path.
        if (is_jump_i || id_ready_i) begin
          state_d = IF_S_REQ;
`ifdef IF_MISALIGN_CHECK_EN
          excp_d  = 1'b0;
`endif
        end
        if (is_jump_i) pc_d = pc_next_i;
      end
      default: state_d = IF_S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) excp_q <= 1'b0;
    else     excp_q <= excp_d;
  end
`endif

  if_fetch_stage_hold_buf #(
    .XLEN     (XLEN),
    .INST_LEN (INST_LEN)
  ) u_hold_buf (
    .clk       (clk),
    .clr_i     (rst),
    .load_i    (hold_ld),
    .present_i (~rst),
    .pc_i      (pc_q),
    .instr_i   (hold_instr_d),
    .pc_o      (pc_if_o),
    .instr_o   (instr_if_o)
  );

endmodule
